// File: rtl/stack_ctrl.sv
// Data-stack controller: TOS/NOS in registers, deeper entries spilled to a
// synchronous RAM, with depth tracking and sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int W     = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  tos,
  output logic [W-1:0]  nos,
  output logic [AW+1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  typedef enum logic {IDLE, REFILL} state_t;

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_P2P  = 3'd3;
  localparam logic [2:0] OP_DUP  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_OVER = 3'd6;

  localparam logic [AW+1:0] CAP = (AW+2)'(DEPTH + 2);
  localparam logic [AW+1:0] D1  = (AW+2)'(1);
  localparam logic [AW+1:0] D2  = (AW+2)'(2);
  localparam logic [AW+1:0] D3  = (AW+2)'(3);

  state_t        state_q, state_d;
  logic [W-1:0]  tos_q, tos_d;
  logic [W-1:0]  nos_q, nos_d;
  logic [AW+1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  rdata_q;
  logic          we, re, pop_v;
  logic          acc, is_empty, is_full, has2, has3;
  logic [AW-1:0] waddr, raddr;

  assign op_ready = rst_n && (state_q == IDLE);
  assign acc      = op_valid && op_ready;
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == CAP);
  assign has2     = (depth_q >= D2);
  assign has3     = (depth_q >= D3);
  // RAM holds depth-2 entries; next free slot is sp, top is sp-1
  assign waddr    = AW'(depth_q - D2);
  assign raddr    = AW'(depth_q - D3);

  always_comb begin
    state_d = state_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    re      = 1'b0;
    pop_v   = 1'b0;
    if (state_q == REFILL) begin
      nos_d   = rdata_q;
      state_d = IDLE;
    end else if (acc) begin
      case (op)
        OP_PUSH: begin
          if (is_full) ovf_d = 1'b1;
          else begin
            we      = has2;
            nos_d   = tos_q;
            tos_d   = din;
            depth_d = depth_q + D1;
          end
        end
        OP_DUP: begin
          if (is_empty) unf_d = 1'b1;
          else if (is_full) ovf_d = 1'b1;
          else begin
            we      = has2;
            nos_d   = tos_q;
            depth_d = depth_q + D1;
          end
        end
        OP_OVER: begin
          if (!has2) unf_d = 1'b1;
          else if (is_full) ovf_d = 1'b1;
          else begin
            we      = 1'b1;
            nos_d   = tos_q;
            tos_d   = nos_q;
            depth_d = depth_q + D1;
          end
        end
        OP_SWAP: begin
          if (!has2) unf_d = 1'b1;
          else begin
            nos_d = tos_q;
            tos_d = nos_q;
          end
        end
        OP_POP: begin
          if (is_empty) unf_d = 1'b1;
          else begin
            tos_d   = nos_q;
            depth_d = depth_q - D1;
            pop_v   = 1'b1;
          end
        end
        OP_P2P: begin
          if (!has2) unf_d = 1'b1;
          else begin
            tos_d   = din;
            depth_d = depth_q - D1;
            pop_v   = 1'b1;
          end
        end
        default: ;
      endcase
      if (pop_v) begin
        if (has3) begin
          re      = 1'b1;
          state_d = REFILL;
        end else begin
          nos_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= nos_q;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign tos   = tos_q;
  assign nos   = nos_q;
  assign depth = depth_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomised scoreboard bench for stack_ctrl against a queue-based
// reference stack.
module tb_stack_ctrl;

  localparam int CAP = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [15:0] din;
  logic [15:0] tos, nos;
  logic [6:0]  depth;
  logic        empty, full, ovf, unf;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .din(din), .tos(tos), .nos(nos), .depth(depth),
    .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] tos;
    logic [15:0] nos;
    logic [6:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic [1:0]  lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [2:0]  opq[$];
  logic [15:0] stk[$];
  logic        m_ovf, m_unf;
  int          checks = 0;
  int          errors = 0;
  bit          pend = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  // Reference: the stack is a queue, top at the back
  task automatic model(input logic [2:0] o, input logic [15:0] d,
                       output exp_t e);
    int n;
    logic [15:0] t, u;
    n = stk.size();
    e.lat = 2'd1;
    case (o)
      3'd1: if (n >= CAP) m_ovf = 1; else stk.push_back(d);
      3'd2: if (n < 1) m_unf = 1;
            else begin
              t = stk.pop_back();
              if (n > 2) e.lat = 2'd2;
            end
      3'd3: if (n < 2) m_unf = 1;
            else begin
              t = stk.pop_back();
              t = stk.pop_back();
              stk.push_back(d);
              if (n > 2) e.lat = 2'd2;
            end
      3'd4: if (n < 1) m_unf = 1;
            else if (n >= CAP) m_ovf = 1;
            else stk.push_back(stk[n-1]);
      3'd5: if (n < 2) m_unf = 1;
            else begin
              t = stk[n-1];
              u = stk[n-2];
              stk[n-1] = u;
              stk[n-2] = t;
            end
      3'd6: if (n < 2) m_unf = 1;
            else if (n >= CAP) m_ovf = 1;
            else stk.push_back(stk[n-2]);
      default: ;
    endcase
    n = stk.size();
    e.tos   = (n > 0) ? stk[n-1] : 16'd0;
    e.nos   = (n > 1) ? stk[n-2] : 16'd0;
    e.depth = 7'(n);
    e.empty = (n == 0);
    e.full  = (n == CAP);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [15:0] d,
                       input bit rst_mid = 0);
    exp_t e;
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    op_valid = 1; op = o; din = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (op_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept timeout op=%0d", o);
    end else begin
      model(o, d, e);
      exp_q.push_back(e);
      opq.push_back(o);
    end
    @(posedge clk); #1;
    if (rst_mid) rst_n = 0;
    op_valid = 0; op = 3'($urandom); din = 16'($urandom);
  endtask

  task automatic chk_reset();
    chk("rst_ready", {31'd0, op_ready}, 32'd0);
    chk("rst_tos", {16'd0, tos}, 32'd0);
    chk("rst_nos", {16'd0, nos}, 32'd0);
    chk("rst_depth", {25'd0, depth}, 32'd0);
    chk("rst_flags", {28'd0, empty, full, ovf, unf}, 32'h8);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (stk.size() > 0 && g < 100) begin
      do_op(3'd2, 16'($urandom));
      g++;
    end
  endtask

  // Monitor: an op completes at the first falling edge with ready high
  always @(negedge clk) begin
    exp_t e, a;
    logic [2:0] o;
    if (!rst_n) begin
      exp_q.delete();
      opq.delete();
      pend = 0;
    end else begin
      if (pend) begin
        if (op_ready) begin
          pend = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard no expectation");
          end else begin
            e = exp_q.pop_front();
            o = opq.pop_front();
            a = '{tos, nos, depth, empty, full, ovf, unf, 2'(cyc + 1)};
            if (a !== e) begin
              errors++;
              $display("FAIL op%0d got tos=%h nos=%h dep=%0d efou=%b%b%b%b lat=%0d want tos=%h nos=%h dep=%0d efou=%b%b%b%b lat=%0d",
                o, a.tos, a.nos, a.depth, a.empty, a.full, a.ovf, a.unf,
                a.lat, e.tos, e.nos, e.depth, e.empty, e.full, e.ovf,
                e.unf, e.lat);
            end
          end
        end else begin
          cyc++;
          if (cyc > 4) begin
            pend = 0;
            checks++; errors++;
            $display("FAIL completion timeout");
          end
        end
      end
      if (op_valid && op_ready) begin
        pend = 1;
        cyc = 0;
      end
    end
  end

  initial begin
    exp_t e;
    int r;
    m_ovf = 0; m_unf = 0;
    rst_n = 0; op_valid = 0; op = 3'd1; din = 16'hdead;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1; rst_n = 1;

    // 1: basic push
    do_op(3'd1, 16'd5);
    do_op(3'd1, 16'd7);
    drain();
    // 2: pops with refill
    for (int i = 1; i <= 6; i++) do_op(3'd1, 16'(i));
    repeat (3) do_op(3'd2, 16'd0);
    drain();
    // 3: pop2push shallow and deep
    do_op(3'd1, 16'd3); do_op(3'd1, 16'd4); do_op(3'd3, 16'd7);
    drain();
    do_op(3'd1, 16'd2); do_op(3'd1, 16'd3); do_op(3'd1, 16'd4);
    do_op(3'd3, 16'd7);
    drain();
    // 4: swap/over/dup
    do_op(3'd1, 16'd9); do_op(3'd1, 16'd2);
    do_op(3'd5, 16'd0); do_op(3'd6, 16'd0); do_op(3'd4, 16'd0);
    drain();
    // 5: fill, overflow, LIFO drain
    for (int i = 0; i < CAP; i++) do_op(3'd1, 16'(100 + i * 3));
    do_op(3'd1, 16'd99);
    do_op(3'd4, 16'd0);
    drain();
    // 6: underflow, reset during refill
    do_op(3'd2, 16'd0);
    do_op(3'd1, 16'd11);
    do_op(3'd5, 16'd0);
    do_op(3'd3, 16'd1);
    do_op(3'd1, 16'd12); do_op(3'd1, 16'd13); do_op(3'd1, 16'd14);
    do_op(3'd2, 16'd0, 1);
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    stk.delete(); m_ovf = 0; m_unf = 0;
    @(posedge clk); #1; rst_n = 1;

    // random: alternate push-heavy and pop-heavy phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int k = 0; k < 150; k++) begin
        r = $urandom_range(0, 9);
        if (r < 5) do_op((ph % 2 == 0) ? 3'd1 : 3'd2, 16'($urandom));
        else do_op(3'($urandom_range(0, 7)), 16'($urandom));
      end
    end
    drain();

    repeat (3) @(posedge clk);
    chk("sb_empty", exp_q.size() + (pend ? 1 : 0), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
